// File: rtl/tt_um_nasser_hadi_serial_alu.sv
// Bit-serial add/subtract ALU: operands are captured on a start edge, summed LSB
// first through a single full adder, and the result/carry/overflow published on DONE.
module tt_um_nasser_hadi_serial_alu #(
  parameter int WIDTH = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic             start_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sub_q;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] result;
  logic             carry_q;
  logic             ovf_q;

  logic             start;
  logic             sub;
  logic             acc;
  logic             start_pulse;
  logic             last;
  logic             b_eff;
  logic             s;
  logic             c_nx;
  logic [WIDTH-1:0] res_nx;
  logic             unused_bits;

  assign start       = uio_in[0];
  assign sub         = uio_in[1];
  assign acc         = uio_in[2];
  assign start_pulse = start & ~start_q;
  assign last        = (cnt == LAST);

  // Full adder from two half adders; B is inverted for subtraction with carry-in = 1.
  assign b_eff  = b_sh[0] ^ sub_q;
  assign s      = a_sh[0] ^ b_eff ^ c;
  assign c_nx   = (a_sh[0] & b_eff) | (c & (a_sh[0] ^ b_eff));
  assign res_nx = (res_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_pulse) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sub_q   <= 1'b0;
      c       <= 1'b0;
      cnt     <= '0;
      res_sh  <= '0;
      result  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (ena) begin
      start_q <= start;
      unique case (state)
        IDLE: begin
          if (start_pulse) begin
            a_sh  <= ui_in[WIDTH-1:0];
            b_sh  <= acc ? result : ui_in[4 +: WIDTH];
            sub_q <= sub;
            c     <= sub;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c      <= c_nx;
          res_sh <= res_nx;
          cnt    <= cnt + CNT_W'(1);
          // On the MSB, c is the carry in and c_nx the carry out.
          if (last) begin
            result  <= res_nx;
            carry_q <= c_nx;
            ovf_q   <= c ^ c_nx;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    uo_out            = '0;
    uo_out[WIDTH-1:0] = result;
    uo_out[4]         = carry_q;
    uo_out[5]         = (state != IDLE);
    uo_out[6]         = (state == DONE);
    uo_out[7]         = ovf_q;
  end

  assign uio_out     = '0;
  assign uio_oe      = '0;
  assign unused_bits = &{1'b0, ui_in, uio_in[7:3]};

endmodule
